// File: rtl/alarm_ctrl_if.sv
// Button, tick and clock-digit inputs plus alarm-digit, mux-select, buzzer and mode
// outputs of the alarm controller.
interface alarm_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_stop;
  logic       alarm_en;
  logic [3:0] a0, a1, a2, a3;
  logic [3:0] b0, b1, b2, b3;
  logic       alarm;
  logic       buzzer;
  logic [2:0] mode;

  modport master (
    output tick_1hz, btn_mode, btn_inc, btn_stop, alarm_en, a0, a1, a2, a3,
    input  b0, b1, b2, b3, alarm, buzzer, mode
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, btn_stop, alarm_en, a0, a1, a2, a3,
    output b0, b1, b2, b3, alarm, buzzer, mode
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock mode controller: holds the BCD alarm time, sequences view/set modes
// from buttons, rings the buzzer when the clock time reaches the alarm time.
module alarm_ctrl #(
  parameter int RING_SECS    = 60,
  parameter int EDIT_TIMEOUT = 10
) (
  input logic         clk,
  input logic         reset,
  alarm_ctrl_if.slave bus
);

  // state | meaning
  // TIME  | normal clock display, alarm armed for triggering
  // VIEW  | show alarm digits
  // SET_H | show alarm digits, btn_inc steps hours
  // SET_M | show alarm digits, btn_inc steps minutes
  // RING  | buzzer on until stop, disarm or ring timeout
  typedef enum logic [2:0] {
    S_TIME  = 3'd0,
    S_VIEW  = 3'd1,
    S_SET_H = 3'd2,
    S_SET_M = 3'd3,
    S_RING  = 3'd4
  } state_t;

  localparam logic [7:0] IDLE_LOAD = 8'(EDIT_TIMEOUT);
  localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

  state_t     state, state_nxt;
  logic [7:0] idle_rem, ring_rem;
  logic [3:0] b0_q, b1_q, b2_q, b3_q;
  logic [3:0] hr_t, hr_u, mn_t, mn_u;
  logic       match, match_q;
  logic       any_btn, edit, ring_trig, idle_tc, ring_tc;
  logic       inc_h, inc_m;
  logic       alarm_d, buzzer_d, alarm_q, buzzer_q;

  assign any_btn   = bus.btn_mode | bus.btn_inc | bus.btn_stop;
  assign match     = ({bus.a3, bus.a2, bus.a1, bus.a0} == {b3_q, b2_q, b1_q, b0_q});
  assign edit      = (state == S_VIEW) || (state == S_SET_H) || (state == S_SET_M);
  assign ring_trig = bus.alarm_en & match & ~match_q;
  // A button in the same clk as the last tick reloads the timer, so no exit.
  assign idle_tc   = bus.tick_1hz & ~any_btn & (idle_rem == 8'd1);
  assign ring_tc   = bus.tick_1hz & (ring_rem == 8'd1);
  assign inc_h     = (state == S_SET_H) & bus.btn_inc & ~bus.btn_mode;
  assign inc_m     = (state == S_SET_M) & bus.btn_inc & ~bus.btn_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_TIME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_TIME: begin
        if (ring_trig)         state_nxt = S_RING;
        else if (bus.btn_mode) state_nxt = S_VIEW;
      end
      S_VIEW: begin
        if (bus.btn_mode)      state_nxt = S_SET_H;
        else if (idle_tc)      state_nxt = S_TIME;
      end
      S_SET_H: begin
        if (bus.btn_mode)      state_nxt = S_SET_M;
        else if (idle_tc)      state_nxt = S_TIME;
      end
      S_SET_M: begin
        if (bus.btn_mode)      state_nxt = S_TIME;
        else if (idle_tc)      state_nxt = S_TIME;
      end
      S_RING: begin
        if (bus.btn_stop || !bus.alarm_en || ring_tc) state_nxt = S_TIME;
      end
      default: state_nxt = S_TIME;
    endcase
  end

  always_comb begin
    alarm_d  = (state_nxt == S_VIEW) || (state_nxt == S_SET_H) || (state_nxt == S_SET_M);
    buzzer_d = (state_nxt == S_RING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q  <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      alarm_q  <= alarm_d;
      buzzer_q <= buzzer_d;
    end
  end

  // Timers count remaining seconds down and fire on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_rem <= 8'd0;
      ring_rem <= 8'd0;
    end else begin
      if (any_btn)
        idle_rem <= IDLE_LOAD;
      else if (edit && bus.tick_1hz && idle_rem != 8'd0)
        idle_rem <= idle_rem - 8'd1;

      if (state == S_TIME && state_nxt == S_RING)
        ring_rem <= RING_LOAD;
      else if (state == S_RING && bus.tick_1hz && ring_rem != 8'd0)
        ring_rem <= ring_rem - 8'd1;
    end
  end

  always_comb begin
    if (b3_q == 4'd2 && b2_q == 4'd3) begin
      hr_t = 4'd0;
      hr_u = 4'd0;
    end else if (b2_q == 4'd9) begin
      hr_t = b3_q + 4'd1;
      hr_u = 4'd0;
    end else begin
      hr_t = b3_q;
      hr_u = b2_q + 4'd1;
    end

    if (b1_q == 4'd5 && b0_q == 4'd9) begin
      mn_t = 4'd0;
      mn_u = 4'd0;
    end else if (b0_q == 4'd9) begin
      mn_t = b1_q + 4'd1;
      mn_u = 4'd0;
    end else begin
      mn_t = b1_q;
      mn_u = b0_q + 4'd1;
    end
  end

  // match_q resets high so a match already present at reset never rings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b0_q    <= 4'd0;
      b1_q    <= 4'd0;
      b2_q    <= 4'd0;
      b3_q    <= 4'd0;
      match_q <= 1'b1;
    end else begin
      match_q <= match;
      if (inc_h) begin
        b3_q <= hr_t;
        b2_q <= hr_u;
      end
      if (inc_m) begin
        b1_q <= mn_t;
        b0_q <= mn_u;
      end
    end
  end

  assign bus.b0     = b0_q;
  assign bus.b1     = b1_q;
  assign bus.b2     = b2_q;
  assign bus.b3     = b3_q;
  assign bus.alarm  = alarm_q;
  assign bus.buzzer = buzzer_q;
  assign bus.mode   = state;

endmodule
